rot_addr_nav: RTL and testbench



---
 rtl/rot_addr_nav.sv | 148 ++++++++++++++
 tb/tb_rot_addr_nav.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_addr_nav.sv
// Multi-channel address navigator driven by a quadrature rotary encoder and push button.
// Each detent steps the selected channel up or down (wrap or saturate), accelerating on fast turns.
module rot_addr_nav #(
    parameter int CHANNELS    = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int ADDR_WIDTH  = 5,
    parameter int ADDR_MAX    = 2**ADDR_WIDTH-1,
    parameter int MODE_SAT    = 0,
    parameter int FAST_STEP   = 4,
    parameter int FAST_WINDOW = 200000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           rot_a,
    input  logic                           rot_b,
    input  logic                           rot_ctr,
    input  logic [SEL_WIDTH-1:0]           sel,
    output logic [ADDR_WIDTH-1:0]          addr,
    output logic [CHANNELS*ADDR_WIDTH-1:0] addr_all,
    output logic                           step_pulse,
    output logic                           step_dir
);

    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int GAP_W = $clog2(FAST_WINDOW + 1);

    localparam logic [ADDR_WIDTH:0] MAX_X   = AW1'(ADDR_MAX);
    localparam logic [ADDR_WIDTH:0] RANGE_X = AW1'(ADDR_MAX + 1);
    localparam logic [ADDR_WIDTH:0] FAST_X  = AW1'(FAST_STEP);
    localparam logic [ADDR_WIDTH:0] ONE_X   = AW1'(1);
    localparam logic [GAP_W-1:0]    WIN_X   = GAP_W'(FAST_WINDOW);

    // Bit order in the input pipeline: [2] = push, [1] = phase B, [0] = phase A.
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] hist_q,  hist_d;

    logic up_q,   up_d;
    logic down_q, down_d;
    logic push_q, push_d;

    logic [ADDR_WIDTH-1:0] ch_q [CHANNELS];
    logic [ADDR_WIDTH-1:0] ch_d [CHANNELS];
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  step_dir_q, step_dir_d;
    logic                  step_pulse_q, step_pulse_d;

    logic                  sel_ok;
    logic                  step_req;
    logic [ADDR_WIDTH:0]   cur_x;
    logic [ADDR_WIDTH:0]   stp_x;
    logic [ADDR_WIDTH:0]   sum_x;
    logic [ADDR_WIDTH:0]   nxt_x;

    // Synchroniser, edge history and a registered decode stage; runs regardless of en.
    always_comb begin
        sync1_d = {rot_ctr, rot_b, rot_a};
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        down_d  = sync2_q[0] & ~hist_q[0] & ~sync2_q[1];
        up_d    = sync2_q[1] & ~hist_q[1] & ~sync2_q[0];
        push_d  = sync2_q[2] & ~hist_q[2];
    end

    always_comb begin
        sel_ok = 32'(sel) < 32'(CHANNELS);
        addr   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (32'(sel) == 32'(i)) addr = ch_q[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_all
        assign addr_all[g*ADDR_WIDTH +: ADDR_WIDTH] = ch_q[g];
    end

    // Step arithmetic is done one bit wider so the wrap/clamp compares cannot overflow.
    always_comb begin
        cur_x = {1'b0, addr};
        stp_x = ((up_q == step_dir_q) && (gap_q < WIN_X)) ? FAST_X : ONE_X;
        sum_x = cur_x + stp_x;
        if (up_q) begin
            if (sum_x > MAX_X) nxt_x = (MODE_SAT != 0) ? MAX_X : sum_x - RANGE_X;
            else               nxt_x = sum_x;
        end else begin
            if (cur_x < stp_x) nxt_x = (MODE_SAT != 0) ? '0 : cur_x + RANGE_X - stp_x;
            else               nxt_x = cur_x - stp_x;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        ch_d         = ch_q;
        gap_d        = (gap_q == WIN_X) ? gap_q : gap_q + 1'b1;
        step_dir_d   = step_dir_q;
        step_pulse_d = 1'b0;
        step_req     = (up_q | down_q) & en & sel_ok;

        if (push_q) begin
            // A push wins over a coincident step; the step leaves no trace.
            for (int i = 0; i < CHANNELS; i++) begin
                if (32'(sel) == 32'(i)) ch_d[i] = '0;
            end
        end else if (step_req) begin
            step_dir_d = up_q;
            gap_d      = '0;
            if (nxt_x != cur_x) begin
                step_pulse_d = 1'b1;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (32'(sel) == 32'(i)) ch_d[i] = nxt_x[ADDR_WIDTH-1:0];
                end
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            hist_q       <= '0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            push_q       <= 1'b0;
            gap_q        <= WIN_X;
            step_dir_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            // NOTE: the channel array is a handful of flops, not a RAM, so it is reset like any other state.
            for (int i = 0; i < CHANNELS; i++) ch_q[i] <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            up_q         <= up_d;
            down_q       <= down_d;
            push_q       <= push_d;
            gap_q        <= gap_d;
            step_dir_q   <= step_dir_d;
            step_pulse_q <= step_pulse_d;
            for (int i = 0; i < CHANNELS; i++) ch_q[i] <= ch_d[i];
        end
    end

    assign step_pulse = step_pulse_q;
    assign step_dir   = step_dir_q;

endmodule

// File: tb/tb_rot_addr_nav.sv
// Bench for rot_addr_nav: a wrap-mode and a saturate-mode instance driven by directed detents,
// with a reference model pushing expected results into per-instance scoreboards.
module tb_rot_addr_nav;

    localparam int CH   = 4;
    localparam int SW   = 3;
    localparam int AW   = 5;
    localparam int AMAX = 31;
    localparam int FS   = 4;
    localparam int FW   = 40;

    typedef struct {
        int              cyc;
        bit              pulse;
        bit              dir;
        logic [CH*AW-1:0] all;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [SW-1:0] sel = '0;
    logic          a_w = 1'b0, b_w = 1'b0, c_w = 1'b0;
    logic          a_s = 1'b0, b_s = 1'b0, c_s = 1'b0;

    logic [AW-1:0]    addr_w, addr_s;
    logic [CH*AW-1:0] addr_all_w, addr_all_s;
    logic             step_pulse_w, step_pulse_s;
    logic             step_dir_w, step_dir_s;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;

    int   m_ch   [2][CH];
    bit   m_dir  [2];
    int   m_last [2];
    exp_t q_w[$];
    exp_t q_s[$];

    rot_addr_nav #(
        .CHANNELS(CH), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .ADDR_MAX(AMAX),
        .MODE_SAT(0), .FAST_STEP(FS), .FAST_WINDOW(FW)
    ) dut_w (
        .clk(clk), .rst(rst), .en(en), .rot_a(a_w), .rot_b(b_w), .rot_ctr(c_w),
        .sel(sel), .addr(addr_w), .addr_all(addr_all_w),
        .step_pulse(step_pulse_w), .step_dir(step_dir_w)
    );

    rot_addr_nav #(
        .CHANNELS(CH), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .ADDR_MAX(AMAX),
        .MODE_SAT(1), .FAST_STEP(FS), .FAST_WINDOW(FW)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .rot_a(a_s), .rot_b(b_s), .rot_ctr(c_s),
        .sel(sel), .addr(addr_s), .addr_all(addr_all_s),
        .step_pulse(step_pulse_s), .step_dir(step_dir_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [CH*AW-1:0] pack(input int d);
        logic [CH*AW-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i*AW +: AW] = AW'(m_ch[d][i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CH; i++) m_ch[d][i] = 0;
            m_dir[d]  = 1'b0;
            m_last[d] = -1;
        end
    endtask

    // Called at the negedge where the encoder inputs change; the next posedge first samples them.
    task automatic model_event(input int d, input bit up, input bit push);
        int   k, gap, s, cur, nxt, si;
        bit   pulse;
        exp_t e;
        k     = cyc + 1;
        si    = int'(sel);
        pulse = 1'b0;
        if (push) begin
            if (si < CH) m_ch[d][si] = 0;
        end else if (en && si < CH) begin
            gap = (m_last[d] < 0) ? FW : (k + 2 - m_last[d]);
            if (gap > FW) gap = FW;
            s   = (up == m_dir[d] && gap < FW) ? FS : 1;
            cur = m_ch[d][si];
            if (d == 0) nxt = up ? (cur + s) % (AMAX + 1) : (cur - s + AMAX + 1) % (AMAX + 1);
            else        nxt = up ? ((cur + s > AMAX) ? AMAX : cur + s) : ((cur - s < 0) ? 0 : cur - s);
            pulse       = (nxt != cur);
            m_ch[d][si] = nxt;
            m_dir[d]    = up;
            m_last[d]   = k + 3;
        end
        e.cyc   = k + 3;
        e.pulse = pulse;
        e.dir   = m_dir[d];
        e.all   = pack(d);
        if (d == 0) q_w.push_back(e);
        else        q_s.push_back(e);
    endtask

    task automatic drive(input int d, input int ph, input logic v);
        if (d == 0) begin
            if (ph == 0) a_w = v; else if (ph == 1) b_w = v; else c_w = v;
        end else begin
            if (ph == 0) a_s = v; else if (ph == 1) b_s = v; else c_s = v;
        end
    endtask

    // One full detent: leading phase rises, trailing follows, both fall. span >= 8 cycles.
    task automatic turn(input int d, input bit up, input bit push, input int span);
        int lead, trail;
        lead  = up ? 1 : 0;
        trail = 1 - lead;
        model_event(d, up, push);
        drive(d, lead, 1'b1);
        if (push) drive(d, 2, 1'b1);
        repeat (2) @(negedge clk);
        drive(d, trail, 1'b1);
        if (push) drive(d, 2, 1'b0);
        repeat (2) @(negedge clk);
        drive(d, lead, 1'b0);
        repeat (2) @(negedge clk);
        drive(d, trail, 1'b0);
        repeat (span - 6) @(negedge clk);
    endtask

    task automatic mon_one(input int d);
        exp_t             e;
        bit               has;
        logic             pulse, dir;
        logic [CH*AW-1:0] all;
        string            nm;
        has = 1'b0;
        nm  = (d == 0) ? "wrap" : "sat";
        if (d == 0) begin
            pulse = step_pulse_w; dir = step_dir_w; all = addr_all_w;
            if (q_w.size() != 0 && q_w[0].cyc <= cyc) begin e = q_w.pop_front(); has = 1'b1; end
        end else begin
            pulse = step_pulse_s; dir = step_dir_s; all = addr_all_s;
            if (q_s.size() != 0 && q_s[0].cyc <= cyc) begin e = q_s.pop_front(); has = 1'b1; end
        end
        if (has) begin
            check($sformatf("%s_pulse@%0d", nm, cyc), 32'(pulse), 32'(e.pulse));
            check($sformatf("%s_dir@%0d", nm, cyc),   32'(dir),   32'(e.dir));
            check($sformatf("%s_all@%0d", nm, cyc),   32'(all),   32'(e.all));
        end else begin
            check($sformatf("%s_idle_pulse@%0d", nm, cyc), 32'(pulse), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_one(0);
            mon_one(1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_on = 1'b1;
        check("rst_all_w",  32'(addr_all_w), 32'd0);
        check("rst_all_s",  32'(addr_all_s), 32'd0);
        check("rst_addr_w", 32'(addr_w),     32'd0);
        check("rst_dir_w",  32'(step_dir_w), 32'd0);

        // Three slow up detents on channel 2.
        sel = 3'd2;
        repeat (3) turn(0, 1'b1, 1'b0, 50);
        check("t1_addr", 32'(addr_w),     32'd3);
        check("t1_all",  32'(addr_all_w), 32'h00C00);

        // Wrap through zero in both directions on channel 0.
        sel = 3'd0;
        turn(0, 1'b0, 1'b0, 50);
        check("wrap_dn_addr", 32'(addr_w),     32'd31);
        check("wrap_dn_dir",  32'(step_dir_w), 32'd0);
        turn(0, 1'b1, 1'b0, 50);
        check("wrap_up_addr", 32'(addr_w), 32'd0);

        // Acceleration: 0 -> 1 -> 5 -> 9 -> 10, then a reversal steps by one.
        turn(0, 1'b1, 1'b0, 10);
        turn(0, 1'b1, 1'b0, 10);
        turn(0, 1'b1, 1'b0, 45);
        turn(0, 1'b1, 1'b0, 10);
        check("accel_addr", 32'(addr_w), 32'd10);
        turn(0, 1'b0, 1'b0, 50);
        check("reverse_addr", 32'(addr_w), 32'd9);

        // Window boundary on channel 1: gap 39 is fast, gap 40 is slow.
        sel = 3'd1;
        turn(0, 1'b1, 1'b0, 40);
        turn(0, 1'b1, 1'b0, 41);
        turn(0, 1'b1, 1'b0, 50);
        turn(0, 1'b1, 1'b0, 50);
        check("window_addr", 32'(addr_w), 32'd7);

        // Push and step together: channel cleared, step discarded.
        turn(0, 1'b1, 1'b1, 50);
        check("push_addr", 32'(addr_w),     32'd0);
        check("push_all",  32'(addr_all_w), 32'h00C09);

        en = 1'b0;
        turn(0, 1'b1, 1'b0, 50);
        en = 1'b1;
        check("en0_addr", 32'(addr_w), 32'd0);

        sel = 3'd5;
        check("sel5_addr_now", 32'(addr_w), 32'd0);
        turn(0, 1'b1, 1'b0, 50);
        check("sel5_addr", 32'(addr_w),     32'd0);
        check("sel5_all",  32'(addr_all_w), 32'h00C09);

        // Saturate instance: clamp at 0, climb to 30, then clamp at 31.
        sel = 3'd0;
        turn(1, 1'b0, 1'b0, 10);
        turn(1, 1'b1, 1'b0, 10);
        repeat (6) turn(1, 1'b1, 1'b0, 10);
        turn(1, 1'b1, 1'b0, 45);
        check("sat_29", 32'(addr_s), 32'd29);
        turn(1, 1'b1, 1'b0, 50);
        check("sat_30", 32'(addr_s), 32'd30);
        turn(1, 1'b1, 1'b0, 10);
        turn(1, 1'b1, 1'b0, 50);
        check("sat_31", 32'(addr_s), 32'd31);

        // Mid-operation reset with a detent inside the synchroniser.
        sel = 3'd1;
        turn(0, 1'b1, 1'b0, 10);
        turn(0, 1'b1, 1'b0, 10);
        check("pre_rst_addr", 32'(addr_w), 32'd5);
        a_w = 1'b1;
        @(negedge clk);
        a_w = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        check("post_rst_all_w", 32'(addr_all_w), 32'd0);
        check("post_rst_all_s", 32'(addr_all_s), 32'd0);
        check("post_rst_dir_s", 32'(step_dir_s), 32'd0);

        // First step after reset is slow even in the reset direction.
        sel = 3'd0;
        turn(0, 1'b0, 1'b0, 10);
        check("post_rst_step", 32'(addr_w), 32'd31);

        // Two steps detected on consecutive cycles are both applied.
        model_event(0, 1'b1, 1'b0);
        b_w = 1'b1;
        @(negedge clk);
        model_event(0, 1'b0, 1'b0);
        b_w = 1'b0;
        a_w = 1'b1;
        @(negedge clk);
        a_w = 1'b0;
        repeat (10) @(negedge clk);
        check("back2back_addr", 32'(addr_w), 32'd31);

        check("sb_w_empty", 32'(q_w.size()), 32'd0);
        check("sb_s_empty", 32'(q_s.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
